if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, driving the IF/ID pipeline register. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents {PC+4, instruction} to IF/ID every cycle. It handles decode-stage stalls and branch/jump redirects; when it has no valid instruction, it emits a bubble (`ins` = 32'h0, `sll $0,$0,0`). Because IF/ID samples on every `clk` edge and has no enable, this block re-presents its held outputs during a stall.

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_skid_buf.sv | 39 +++
 rtl/if_fetch.sv | 144 ++++++++++++++
 tb/tb_if_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INS          = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pcp4, ins} holding buffer used while decode is stalled.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic        full
);

    logic [63:0] data_q, data_d;
    logic        full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks to imem and feeds IF/ID,
// absorbing decode stalls and branch/jump redirects.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcp4,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  pcp4_q, pcp4_d;
    logic [31:0]  ins_q, ins_d;
    logic         vld_q, vld_d;

    logic [31:0]  rpc;
    logic [31:0]  pc_inc;
    logic         busy;
    logic         skid_ld;
    logic         skid_clr;
    logic         skid_full;
    logic [63:0]  skid_dout;

    assign rpc    = redirect_pc & ~32'h3;
    assign pc_inc = pc_q + PC_STEP;
    assign busy   = (state_q != HOLD);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        pcp4_d   = pcp4_q;
        ins_d    = ins_q;
        vld_d    = vld_q;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;

        if (redirect) begin
            pcp4_d   = '0;
            ins_d    = NOP_INS;
            vld_d    = 1'b0;
            skid_clr = 1'b1;
            // An unacked request cannot be withdrawn, so let it drain.
            if (busy && !imem_ack) begin
                tgt_d   = rpc;
                state_d = DRAIN;
            end else begin
                pc_d    = rpc;
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            skid_ld = 1'b1;
                            state_d = HOLD;
                        end else begin
                            pcp4_d = pc_inc;
                            ins_d  = imem_rdata;
                            vld_d  = 1'b1;
                        end
                    end else if (!stall) begin
                        pcp4_d = '0;
                        ins_d  = NOP_INS;
                        vld_d  = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall && skid_full) begin
                        pcp4_d   = skid_dout[63:32];
                        ins_d    = skid_dout[31:0];
                        vld_d    = 1'b1;
                        skid_clr = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        pcp4_d = '0;
                        ins_d  = NOP_INS;
                        vld_d  = 1'b0;
                    end
                    if (imem_ack) begin
                        pc_d    = tgt_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            pcp4_q  <= '0;
            ins_q   <= NOP_INS;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pcp4_q  <= pcp4_d;
            ins_q   <= ins_d;
            vld_q   <= vld_d;
        end
    end

    if_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_ld),
        .clear (skid_clr),
        .din   ({pc_inc, imem_rdata}),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    assign imem_req  = busy;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pcp4      = pcp4_q;
    assign ins       = ins_q;
    assign ins_valid = vld_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed tables, corner sequences
// and a randomized run against a queue-based reference model.
module tb_if_fetch;

    localparam logic [31:0] XK = 32'hA5A5_0000;

    typedef struct {
        int          wt;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        er;
        logic [31:0] ea;
        logic [31:0] ep;
        logic [31:0] ei;
        logic        ev;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        stall, redirect, stall2, redirect2;
    logic [31:0] redirect_pc, redirect_pc2;
    logic        imem_req, imem_ack, imem_req2, imem_ack2;
    logic [31:0] imem_addr, imem_rdata, imem_addr2, imem_rdata2;
    logic [31:0] pcp4, ins, pc, pcp42, ins2, pc2;
    logic        ins_valid, ins_valid2;

    int tests = 0;
    int failed = 0;

    int       fixed_wait = 0;
    int       fixed_wait2 = 0;
    bit       rand_mode = 1'b0;
    int       cnt, wait_n, cnt2, wait2_n;

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pcp4(pcp4), .ins(ins),
        .ins_valid(ins_valid), .pc(pc)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2),
        .imem_addr(imem_addr2), .imem_ack(imem_ack2),
        .imem_rdata(imem_rdata2), .pcp4(pcp42), .ins(ins2),
        .ins_valid(ins_valid2), .pc(pc2)
    );

    // Memory models: ack after wait_n idle request cycles.
    assign imem_ack    = imem_req && (cnt == wait_n);
    assign imem_rdata  = imem_addr ^ XK;
    assign imem_ack2   = imem_req2 && (cnt2 == wait2_n);
    assign imem_rdata2 = imem_addr2 ^ XK;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 0;
            wait_n <= fixed_wait;
        end else if (imem_ack) begin
            cnt    <= 0;
            wait_n <= rand_mode ? int'($urandom_range(0, 2)) : fixed_wait;
        end else if (imem_req) begin
            cnt <= cnt + 1;
        end
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            cnt2    <= 0;
            wait2_n <= fixed_wait2;
        end else if (imem_ack2) begin
            cnt2    <= 0;
            wait2_n <= fixed_wait2;
        end else if (imem_req2) begin
            cnt2 <= cnt2 + 1;
        end
    end

    task automatic chk(
        input string       name,
        input logic        ar,
        input logic [31:0] aa,
        input logic [31:0] apc,
        input logic [31:0] ap,
        input logic [31:0] ai,
        input logic        av,
        input logic        er,
        input logic [31:0] ea,
        input logic [31:0] ep,
        input logic [31:0] ei,
        input logic        ev
    );
        tests++;
        if ({ar, aa, apc, ap, ai, av} !== {er, ea, ea, ep, ei, ev}) begin
            failed++;
            $display("FAIL %s: got req=%0b addr=%h pc=%h pcp4=%h ins=%h v=%0b, want req=%0b addr=%h pcp4=%h ins=%h v=%0b",
                     name, ar, aa, apc, ap, ai, av, er, ea, ep, ei, ev);
        end
    endtask

    task automatic row(input string name, input vec_t v);
        @(negedge clk);
        fixed_wait = v.wt;
        chk(name, imem_req, imem_addr, pc, pcp4, ins, ins_valid,
            v.er, v.ea, v.ep, v.ei, v.ev);
        stall       = v.st;
        redirect    = v.rd;
        redirect_pc = v.rpc;
    endtask

    task automatic reset_dut1(input int w, input bit rm);
        @(negedge clk);
        stall     = 1'b0;
        redirect  = 1'b0;
        rand_mode = rm;
        fixed_wait = w;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t tab[19];

    // Reference model state for the random run.
    logic [31:0] m_pc, m_tgt, m_p, m_i;
    logic        m_v, m_drain;
    logic [63:0] m_q[$];

    initial begin
        tab[0]  = '{0, 0, 0, 0, 1, 32'h00, 32'h00, 32'h0, 0};
        tab[1]  = '{0, 0, 0, 0, 1, 32'h04, 32'h04, XK ^ 32'h00, 1};
        tab[2]  = '{0, 0, 0, 0, 1, 32'h08, 32'h08, XK ^ 32'h04, 1};
        tab[3]  = '{0, 0, 0, 0, 1, 32'h0C, 32'h0C, XK ^ 32'h08, 1};
        tab[4]  = '{0, 1, 0, 0, 1, 32'h10, 32'h10, XK ^ 32'h0C, 1};
        tab[5]  = '{0, 1, 0, 0, 0, 32'h14, 32'h10, XK ^ 32'h0C, 1};
        tab[6]  = '{0, 1, 0, 0, 0, 32'h14, 32'h10, XK ^ 32'h0C, 1};
        tab[7]  = '{0, 0, 0, 0, 0, 32'h14, 32'h10, XK ^ 32'h0C, 1};
        tab[8]  = '{0, 0, 0, 0, 1, 32'h14, 32'h14, XK ^ 32'h10, 1};
        tab[9]  = '{0, 1, 1, 32'h40, 1, 32'h18, 32'h18, XK ^ 32'h14, 1};
        tab[10] = '{0, 0, 0, 0, 1, 32'h40, 32'h00, 32'h0, 0};
        tab[11] = '{2, 0, 0, 0, 1, 32'h44, 32'h44, XK ^ 32'h40, 1};
        tab[12] = '{2, 0, 0, 0, 1, 32'h48, 32'h48, XK ^ 32'h44, 1};
        tab[13] = '{2, 0, 0, 0, 1, 32'h48, 32'h00, 32'h0, 0};
        tab[14] = '{2, 0, 0, 0, 1, 32'h48, 32'h00, 32'h0, 0};
        tab[15] = '{2, 0, 0, 0, 1, 32'h4C, 32'h4C, XK ^ 32'h48, 1};
        tab[16] = '{2, 0, 0, 0, 1, 32'h4C, 32'h00, 32'h0, 0};
        tab[17] = '{2, 0, 0, 0, 1, 32'h4C, 32'h00, 32'h0, 0};
        tab[18] = '{2, 0, 0, 0, 1, 32'h50, 32'h50, XK ^ 32'h4C, 1};

        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 0; redirect = 0; redirect_pc = 0;
        stall2 = 0; redirect2 = 0; redirect_pc2 = 0;
        repeat (3) @(negedge clk);
        chk("reset", imem_req, imem_addr, pc, pcp4, ins, ins_valid,
            1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset2", imem_req2, imem_addr2, pc2, pcp42, ins2, ins_valid2,
            1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);

        // Zero-wait stream, stall skid, redirect+stall+ack, 2 wait states.
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 19; i++) row($sformatf("tab%0d", i), tab[i]);

        // Redirect while a 3-wait request to 0x20 is outstanding.
        reset_dut1(0, 1'b0);
        row("drn0", '{3, 0, 1, 32'h20,  1, 32'h00,  32'h0,   32'h0, 0});
        row("drn1", '{3, 0, 0, 0,       1, 32'h20,  32'h0,   32'h0, 0});
        row("drn2", '{3, 0, 1, 32'h103, 1, 32'h20,  32'h0,   32'h0, 0});
        row("drn3", '{3, 0, 0, 0,       1, 32'h20,  32'h0,   32'h0, 0});
        row("drn4", '{0, 0, 0, 0,       1, 32'h20,  32'h0,   32'h0, 0});
        row("drn5", '{0, 0, 0, 0,       1, 32'h100, 32'h0,   32'h0, 0});
        row("drn6", '{0, 0, 0, 0,       1, 32'h104, 32'h104, XK ^ 32'h100, 1});

        // Wrapping reset PC, then reset asserted mid-drain.
        @(posedge clk);
        #1 rst2_n = 1'b1;
        @(negedge clk);
        chk("wrap0", imem_req2, imem_addr2, pc2, pcp42, ins2, ins_valid2,
            1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wrap1", imem_req2, imem_addr2, pc2, pcp42, ins2, ins_valid2,
            1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC ^ XK, 1'b1);
        fixed_wait2 = 3;
        @(negedge clk);
        chk("wrap2", imem_req2, imem_addr2, pc2, pcp42, ins2, ins_valid2,
            1'b1, 32'h4, 32'h4, XK, 1'b1);
        redirect2 = 1'b1;
        redirect_pc2 = 32'h80;
        @(negedge clk);
        redirect2 = 1'b0;
        chk("wrap_drain", imem_req2, imem_addr2, pc2, pcp42, ins2, ins_valid2,
            1'b1, 32'h4, 32'h0, 32'h0, 1'b0);
        rst2_n = 1'b0;
        #1;
        chk("mid_rst", imem_req2, imem_addr2, pc2, pcp42, ins2, ins_valid2,
            1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);

        // Randomized run against the reference model.
        reset_dut1(0, 1'b1);
        m_pc = 0; m_tgt = 0; m_p = 0; m_i = 0; m_v = 0; m_drain = 0;
        m_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic        a, s, r;
            logic [31:0] d, rp;
            @(negedge clk);
            chk("rand", imem_req, imem_addr, pc, pcp4, ins, ins_valid,
                (m_q.size() == 0), m_pc, m_p, m_i, m_v);
            s = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 7) == 0);
            rp = $urandom;
            stall = s; redirect = r; redirect_pc = rp;
            #1;
            a = imem_ack;
            d = imem_rdata;
            if (r) begin
                {m_p, m_i, m_v} = '0;
                if (m_q.size() == 0 && !a) begin
                    m_drain = 1'b1;
                    m_tgt = {rp[31:2], 2'b00};
                end else begin
                    m_drain = 1'b0;
                    m_pc = {rp[31:2], 2'b00};
                end
                m_q.delete();
            end else if (m_drain) begin
                if (!s) {m_p, m_i, m_v} = '0;
                if (a) begin
                    m_drain = 1'b0;
                    m_pc = m_tgt;
                end
            end else if (m_q.size() != 0) begin
                if (!s) begin
                    {m_p, m_i} = m_q.pop_front();
                    m_v = 1'b1;
                end
            end else if (a) begin
                if (s) m_q.push_back({m_pc + 32'd4, d});
                else {m_p, m_i, m_v} = {m_pc + 32'd4, d, 1'b1};
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                {m_p, m_i, m_v} = '0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
